// File: rtl/ysyx_22041211_lsu_bus_pkg.sv
// Shared encodings for the LSU bus block: FSM states, access sizes, load/store codes, lane mask bases.
package ysyx_22041211_lsu_bus_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    // Access size shares the low two bits of both load and store encodings.
    typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} size_t;

    localparam logic [2:0] LD_NONE     = 3'b000;
    localparam logic [1:0] ST_NONE     = 2'b00;
    localparam int         LD_UNSIGNED = 2;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;

    // Load wins when both load and store codes are present.
    function automatic size_t access_size(input logic [2:0] ld, input logic [1:0] st);
        return (ld != LD_NONE) ? size_t'(ld[1:0]) : size_t'(st);
    endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Lane alignment: write mask/shift and misalign detect on the request side, read shift and extension on the response side.
// Purely combinational; no state, no backpressure.
module ysyx_22041211_lsu_align
    import ysyx_22041211_lsu_bus_pkg::*;
#(
    parameter  int DATA_LEN = 32,
    localparam int MASK_LEN = DATA_LEN / 8,
    localparam int OFF_W    = $clog2(MASK_LEN)
) (
    input  logic [OFF_W-1:0]    req_off,
    input  size_t               req_size,
    input  logic [DATA_LEN-1:0] st_data,
    output logic [MASK_LEN-1:0] wmask,
    output logic [DATA_LEN-1:0] wdata,
    output logic                misalign,
    input  logic [OFF_W-1:0]    rsp_off,
    input  logic [2:0]          ld_type,
    input  logic [DATA_LEN-1:0] rdata,
    output logic [DATA_LEN-1:0] ld_data
);

    logic [MASK_LEN-1:0] base_mask;
    logic [DATA_LEN-1:0] shifted;
    logic [DATA_LEN-1:0] low_mask;
    logic                sign_bit;

    always_comb begin
        base_mask = '0;
        case (req_size)
            SZ_B:    base_mask = MASK_LEN'(MASK_B);
            SZ_H:    base_mask = MASK_LEN'(MASK_H);
            SZ_W:    base_mask = MASK_LEN'(MASK_W);
            default: base_mask = '0;
        endcase
    end

    assign wmask    = base_mask << req_off;
    assign wdata    = st_data << {req_off, 3'b000};
    assign misalign = ((req_size == SZ_H) && req_off[0]) ||
                      ((req_size == SZ_W) && (req_off[1:0] != 2'b00));

    always_comb begin
        shifted  = rdata >> {rsp_off, 3'b000};
        low_mask = DATA_LEN'(8'hFF);
        sign_bit = shifted[7];
        case (size_t'(ld_type[1:0]))
            SZ_H: begin
                low_mask = DATA_LEN'(16'hFFFF);
                sign_bit = shifted[15];
            end
            SZ_W: begin
                low_mask = DATA_LEN'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: begin
                low_mask = DATA_LEN'(8'hFF);
                sign_bit = shifted[7];
            end
        endcase
        ld_data = (shifted & low_mask) |
                  ((sign_bit && !ld_type[LD_UNSIGNED]) ? ~low_mask : '0);
    end

endmodule

// File: rtl/ysyx_22041211_lsu_bus.sv
// Multi-cycle LSU: one op in flight, 1 cycle for ALU/misaligned ops, 3 + bus wait states for memory ops; all outputs registered.
// Optional watchdog under YSYX_22041211_LSU_TIMEOUT_EN aborts a stuck bus transaction with a fault.
module ysyx_22041211_lsu_bus
    import ysyx_22041211_lsu_bus_pkg::*;
#(
    parameter int DATA_LEN       = 32,
    parameter int ADDR_LEN       = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exu_valid_i,
    output logic                     lsu_ready_o,
    input  logic [ADDR_LEN-1:0]      addr_i,
    input  logic [DATA_LEN-1:0]      wdata_i,
    input  logic [2:0]               load_type_i,
    input  logic [1:0]               store_type_i,
    input  logic                     wd_i,
    input  logic [4:0]               wreg_i,
    output logic                     lsu_valid_o,
    input  logic                     wb_ready_i,
    output logic                     wd_o,
    output logic [4:0]               wreg_o,
    output logic [DATA_LEN-1:0]      wdata_o,
    output logic                     memory_inst_o,
    output logic                     misalign_o,
    output logic                     fault_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic                     mem_req_we_o,
    output logic [ADDR_LEN-1:0]      mem_req_addr_o,
    output logic [DATA_LEN-1:0]      mem_req_wdata_o,
    output logic [DATA_LEN/8-1:0]    mem_req_wmask_o,
    input  logic                     mem_resp_valid_i,
    output logic                     mem_resp_ready_o,
    input  logic [DATA_LEN-1:0]      mem_resp_rdata_i,
    input  logic                     mem_resp_err_i
);

    localparam int MASK_LEN = DATA_LEN / 8;
    localparam int OFF_W    = $clog2(MASK_LEN);

    state_t              state;
    logic [2:0]          ld_type_q;
    logic [OFF_W-1:0]    off_q;
    logic                is_load, is_store, misalign, timed_out;
    logic [MASK_LEN-1:0] wmask;
    logic [DATA_LEN-1:0] wdata_sh, ld_data;

    assign is_load     = load_type_i != LD_NONE;
    assign is_store    = store_type_i != ST_NONE;
    assign lsu_ready_o = state == S_IDLE;

    ysyx_22041211_lsu_align #(.DATA_LEN(DATA_LEN)) u_align (
        .req_off  (addr_i[OFF_W-1:0]),
        .req_size (access_size(load_type_i, store_type_i)),
        .st_data  (wdata_i),
        .wmask    (wmask),
        .wdata    (wdata_sh),
        .misalign (misalign),
        .rsp_off  (off_q),
        .ld_type  (ld_type_q),
        .rdata    (mem_resp_rdata_i),
        .ld_data  (ld_data)
    );

`ifdef YSYX_22041211_LSU_TIMEOUT_EN
    localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);

    logic [TO_W-1:0] to_cnt;

    // The only way into REQ is an accepted memory op, so clearing on accept covers entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state == S_IDLE) begin
            to_cnt <= '0;
        end else if (state == S_REQ || state == S_RESP) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timed_out = (state == S_REQ || state == S_RESP) && (to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= S_IDLE;
            ld_type_q        <= LD_NONE;
            off_q            <= '0;
            lsu_valid_o      <= 1'b0;
            wd_o             <= 1'b0;
            wreg_o           <= '0;
            wdata_o          <= '0;
            memory_inst_o    <= 1'b0;
            misalign_o       <= 1'b0;
            fault_o          <= 1'b0;
            mem_req_valid_o  <= 1'b0;
            mem_req_we_o     <= 1'b0;
            mem_req_addr_o   <= '0;
            mem_req_wdata_o  <= '0;
            mem_req_wmask_o  <= '0;
            mem_resp_ready_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (exu_valid_i) begin
                    ld_type_q       <= load_type_i;
                    off_q           <= addr_i[OFF_W-1:0];
                    wd_o            <= wd_i;
                    wreg_o          <= wreg_i;
                    wdata_o         <= DATA_LEN'(addr_i);
                    memory_inst_o   <= is_load | is_store;
                    misalign_o      <= 1'b0;
                    fault_o         <= 1'b0;
                    mem_req_addr_o  <= {addr_i[ADDR_LEN-1:OFF_W], {OFF_W{1'b0}}};
                    mem_req_we_o    <= is_store & ~is_load;
                    mem_req_wmask_o <= is_load ? '0 : wmask;
                    mem_req_wdata_o <= wdata_sh;
                    if (!(is_load | is_store)) begin
                        lsu_valid_o <= 1'b1;
                        state       <= S_DONE;
                    end else if (misalign) begin
                        lsu_valid_o <= 1'b1;
                        misalign_o  <= 1'b1;
                        wd_o        <= 1'b0;
                        state       <= S_DONE;
                    end else begin
                        mem_req_valid_o <= 1'b1;
                        state           <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (timed_out) begin
                        mem_req_valid_o <= 1'b0;
                        fault_o         <= 1'b1;
                        wd_o            <= 1'b0;
                        lsu_valid_o     <= 1'b1;
                        state           <= S_DONE;
                    end else if (mem_req_ready_i) begin
                        mem_req_valid_o  <= 1'b0;
                        mem_resp_ready_o <= 1'b1;
                        state            <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (timed_out) begin
                        mem_resp_ready_o <= 1'b0;
                        fault_o          <= 1'b1;
                        wd_o             <= 1'b0;
                        lsu_valid_o      <= 1'b1;
                        state            <= S_DONE;
                    end else if (mem_resp_valid_i) begin
                        mem_resp_ready_o <= 1'b0;
                        lsu_valid_o      <= 1'b1;
                        state            <= S_DONE;
                        if (mem_resp_err_i) begin
                            fault_o <= 1'b1;
                            wd_o    <= 1'b0;
                        end else if (ld_type_q != LD_NONE) begin
                            wdata_o <= ld_data;
                        end
                    end
                end
                S_DONE: if (wb_ready_i) begin
                    lsu_valid_o <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_22041211_lsu_bus.md
# ysyx_22041211_lsu_bus

Parametrised load/store unit that replaces the single-cycle memory stage between EXE and WB. It accepts one memory micro-op per valid/ready handshake and drives a request/response memory bus that tolerates any wait states. It generates lane masks and shifts for any power-of-two `DATA_LEN`, sign- or zero-extends load data, and flags misaligned or faulting accesses. One operation is in flight at a time.

## Interface
- `DATA_LEN`, default 32: bus data width, 32 or 64. `MASK_LEN = DATA_LEN/8`. `OFF_W = $clog2(MASK_LEN)`.
- `ADDR_LEN`, default 32: address width.
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Used only when `YSYX_22041211_LSU_TIMEOUT_EN` is defined.
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: reset, synchronous and active-low.
- `exu_valid_i` in 1 / `lsu_ready_o` out 1: upstream handshake.
- `addr_i` in ADDR_LEN: ALU result, either the memory address or the writeback value.
- `wdata_i` in DATA_LEN: store data, right-aligned.
- `load_type_i` in 3: 000 none, 001 LB, 010 LH, 011 LW, 101 LBU, 110 LHU.
- `store_type_i` in 2: 00 none, 01 SB, 10 SH, 11 SW.
- `wd_i` in 1, `wreg_i` in 5: register-write enable and destination register.
- `lsu_valid_o` out 1 / `wb_ready_i` in 1: downstream handshake.
- `wd_o` out 1, `wreg_o` out 5, `wdata_o` out DATA_LEN: register writeback.
- `memory_inst_o` out 1: the completed op was a load or a store.
- `misalign_o` out 1, `fault_o` out 1: exception flags, valid with `lsu_valid_o`.
- `mem_req_valid_o` out 1, `mem_req_ready_i` in 1, `mem_req_we_o` out 1: bus request handshake and write enable.
- `mem_req_addr_o` out ADDR_LEN, `mem_req_wdata_o` out DATA_LEN, `mem_req_wmask_o` out MASK_LEN: request payload.
- `mem_resp_valid_i` in 1, `mem_resp_ready_o` out 1, `mem_resp_rdata_i` in DATA_LEN, `mem_resp_err_i` in 1: bus response.

## Operation
- FSM states: IDLE, REQ, RESP, DONE. `lsu_ready_o` = (state == IDLE).
- **IDLE**, on `exu_valid_i`: latch all inputs, then:
  - no load and no store → DONE, `wdata_o = addr_i` (zero-extended to DATA_LEN).
  - misaligned → DONE, `misalign_o = 1`, `wd_o = 0`, no bus request. Misaligned means halfword with `addr[0] = 1`, or word with `addr[1:0] != 0`.
  - otherwise → REQ.
- Both `load_type_i` and `store_type_i` nonzero: the load takes priority and the store is ignored.
- **REQ**: `mem_req_valid_o = 1`, payload stable until `mem_req_ready_i`, then → RESP.
  - `mem_req_addr_o` = address with the low OFF_W bits cleared.
  - `mem_req_wmask_o` = base mask (SB 1, SH 3, SW 'hF) << off, where off = `addr[OFF_W-1:0]`. Zero for loads.
  - `mem_req_wdata_o` = `wdata_i << (8*off)`.
- **RESP**: `mem_resp_ready_o = 1`. On `mem_resp_valid_i`, capture the data and → DONE.
  - Load data = `rdata >> (8*off)`, truncated to the access size, then sign- or zero-extended to DATA_LEN.
  - `mem_resp_err_i = 1` → `fault_o = 1`, `wd_o = 0`.
  - Stores also wait for the response, which serves as the write acknowledge.
- **DONE**: `lsu_valid_o = 1` with stable outputs until `wb_ready_i`, then → IDLE.
- Reset: all outputs 0 and state IDLE. Reset mid-operation abandons the transaction. The bus slave must share the same reset.

## Timing
- Non-memory op: accepted in cycle 0, `lsu_valid_o` in cycle 1.
- Memory op with zero-wait bus: REQ in cycle 1, RESP in cycle 2, DONE (`lsu_valid_o`) in cycle 3.
- Each stall cycle on `mem_req_ready_i` or `mem_resp_valid_i` adds exactly one cycle.
- `mem_resp_valid_i` arriving while in REQ is ignored; the slave must not respond before the request handshake.
- `lsu_ready_o` is low from the accept cycle until the cycle after the DONE handshake. The minimum issue interval is 2 cycles for non-memory ops and 4 cycles for memory ops.
- No combinational paths from `*_ready_i` to `*_valid_o`.

## Configuration
- `YSYX_22041211_LSU_TIMEOUT_EN` defined:
  - An 8-to-16-bit counter clears on entry to REQ and increments in REQ/RESP.
  - When the counter reaches `TIMEOUT_CYCLES`: → DONE with `fault_o = 1`, `wd_o = 0`, and `mem_req_valid_o` dropped.
  - A late response is not accepted, because `mem_resp_ready_o` stays 0 outside RESP.
- Undefined: no counter; the unit waits indefinitely.

## Structure
- Shared define header/package: load/store type encodings, FSM state encodings, mask base values.
- Sub-module `ysyx_22041211_lsu_align`: combinational mask, write shift, read shift and extension, misalign detect; parametrised by DATA_LEN.
- FSM, latches and watchdog stay in the top.

## Test plan
- Non-memory op: ALU op `addr_i = 0x1234`, `wd_i = 1` → `lsu_valid_o` next cycle, `wdata_o = 0x1234`, `memory_inst_o = 0`.
- Sign extension:
  - LB at 0x8000_0003, `rdata = 0x80FF_FFFF` → `wdata_o = 0xFFFF_FF80`.
  - LBU at the same address → `wdata_o = 0x80`.
- SH at 0x8000_0002, `wdata_i = 0xABCD` → `wmask = 4'b1100`, `wdata = 0xABCD_0000`, addr 0x8000_0000.
- LW at 0x8000_0001 → `misalign_o = 1`, no `mem_req_valid_o`, `wd_o = 0`.
- Stalls and errors:
  - Req ready delayed 3 cycles, resp delayed 2 cycles → `lsu_valid_o` at cycle 8; `wb_ready_i` held low 2 cycles → outputs stable.
  - `mem_resp_err_i = 1` → `fault_o = 1`.
- Reset and timeout:
  - `rst` low while in RESP → next cycle IDLE, all outputs 0.
  - With the macro, `TIMEOUT_CYCLES = 4` and a silent bus → `fault_o = 1`.
